ultrasonic_echo_responder: RTL
==============================

# ultrasonic_echo_responder

Synthesizable model of an HC-SR04-style ultrasonic ranging sensor: it is the responder end of the trigger/echo interface. It watches the `trigger` line, validates the trigger pulse width, waits a fixed acoustic delay, then drives `echo` high for a programmable number of clock cycles representing target distance. It sits on the FPGA fabric in place of the physical sensor, for hardware-in-the-loop testing of the fuel-level measurement path.

## Interface
- `CLK_MHZ`, 50: clock frequency in MHz.
- `MIN_TRIG_US`, 10: minimum valid trigger high time, in µs.
- `ECHO_DELAY_US`, 250: delay from trigger fall to echo rise, in µs.
- `NO_OBJECT_US`, 38000: echo width when no target is present; also the clamp for `echo_width`.
- `HOLDOFF_US`, 100: dead time after echo fall.
- Derived counts are `CLK_MHZ*<param>`. `CLK_MHZ*NO_OBJECT_US` must be < 2^21.
- `clk` input, 1: system clock.
- `rst` input, 1: asynchronous, active-high reset.
- `trigger` input, 1: trigger from the initiator. Asynchronous; synchronized internally.
- `echo_width` input, 21: echo high time in clk cycles. Sampled once per measurement.
- `no_object` input, 1: when high at the sample point, echo width = `CLK_MHZ*NO_OBJECT_US`.
- `echo` output, 1: registered echo line to the initiator.
- `busy` output, 1: high in every state except IDLE and TRIG_HIGH.
- `trig_error` output, 1: one-cycle pulse when a trigger shorter than the minimum is rejected.
- `done` output, 1: one-cycle pulse on the cycle after `echo` falls.

## Operation
- **Synchronizer**
  - `trigger` passes through a 2-flop synchronizer to `trig_s`.
  - `trig_d` is `trig_s` delayed by one cycle.
  - rise = `trig_s & ~trig_d`; fall = `~trig_s & trig_d`.
- **States:** IDLE, TRIG_HIGH, DELAY, ECHO, HOLDOFF. A single 21-bit counter `cnt` is shared by all states.
- **IDLE**
  - On rise: go to TRIG_HIGH with `cnt`=1.
  - A trigger already high on entry to IDLE is ignored until it falls and rises again.
- **TRIG_HIGH**
  - While `trig_s`=1: `cnt` increments, saturating at all-ones.
  - On fall with `cnt` >= `CLK_MHZ*MIN_TRIG_US`:
    - latch width W (see width rule below);
    - go to DELAY with `cnt`=0.
  - On fall with `cnt` below the minimum: pulse `trig_error` for 1 cycle and go to IDLE.
- **Width rule for W**
  - W = `CLK_MHZ*NO_OBJECT_US` if `no_object`=1.
  - Otherwise W = `echo_width`, clamped to `CLK_MHZ*NO_OBJECT_US`.
  - `echo_width`=0 is treated as W=1.
- **DELAY**
  - Count to `CLK_MHZ*ECHO_DELAY_US`-1, then go to ECHO with `cnt`=0.
  - Trigger activity is ignored.
- **ECHO**
  - `echo`=1 for exactly W cycles.
  - On the last cycle go to HOLDOFF with `cnt`=0.
  - Trigger activity is ignored.
- **HOLDOFF**
  - `done` pulses in the first HOLDOFF cycle.
  - Count `CLK_MHZ*HOLDOFF_US` cycles, then go to IDLE.
  - Rises during HOLDOFF are ignored. They are not queued.
- **Reset**
  - All outputs and all state are cleared asynchronously: state=IDLE, `cnt`=0, `echo`=0, `busy`=0, `trig_error`=0, `done`=0, synchronizer flops=0.
  - Reset asserted during ECHO drops `echo` immediately, with no `done` pulse.
- `echo_width` and `no_object` changes after the sample point do not affect the measurement in progress.

## Timing
- `trigger` pin rise to TRIG_HIGH entry: 3 clk (2 synchronizer cycles + edge register).
- A trigger high for N clk at the pin yields `cnt`=N at the fall decision, with fall/rise latency matched.
  - N = `CLK_MHZ*MIN_TRIG_US` is accepted.
  - N one less is rejected.
- `trigger` pin fall to `echo` rise: 3 + `CLK_MHZ*ECHO_DELAY_US` clk.
- `echo` high time: exactly W clk.
- `done`: asserted 1 cycle after the last `echo`=1 cycle.
- Earliest new accepted rise: detected on the first IDLE cycle after HOLDOFF.
- `trig_error`: asserted the cycle after the fall is detected.

## Test plan
All scenarios use overrides CLK_MHZ=1, MIN_TRIG_US=10, ECHO_DELAY_US=20, HOLDOFF_US=5, NO_OBJECT_US=500.
- **Nominal:** `echo_width`=100, trigger high 12 clk.
  - `echo` rises exactly 23 clk after the trigger fall and stays high 100 clk.
  - `done` pulses once; `busy` drops 6 clk after `echo` falls.
- **Short trigger:** trigger high 9 clk.
  - One `trig_error` pulse, `echo` stays 0, `busy` never asserts.
  - Repeat with 10 clk: accepted.
- **Width edges**
  - `no_object`=1: echo 500 clk.
  - `echo_width`=2000: clamped to 500.
  - `echo_width`=0: echo 1 clk.
  - `echo_width` changed during DELAY: original width kept.
- **Retrigger:** second trigger pulses during DELAY, ECHO and HOLDOFF.
  - All are ignored; timing is unchanged.
  - A trigger held high across HOLDOFF→IDLE is not accepted until it falls and rises again.
- **Reset mid-echo:** assert `rst` 50 clk into ECHO.
  - `echo`=0 asynchronously, no `done`, state IDLE.
  - A subsequent nominal trigger measures correctly.
- **Back-to-back:** 3 triggers, each issued at the first IDLE cycle.
  - 3 echoes with the correct widths and 3 `done` pulses.

Source files
------------

// File: rtl/ultrasonic_echo_responder.sv
// Responder end of an HC-SR04-style trigger/echo link: validates the trigger pulse,
// waits a fixed acoustic delay, drives echo for a sampled width, then holds off.
module ultrasonic_echo_responder #(
    parameter int unsigned CLK_MHZ       = 50,
    parameter int unsigned MIN_TRIG_US   = 10,
    parameter int unsigned ECHO_DELAY_US = 250,
    parameter int unsigned NO_OBJECT_US  = 38000,
    parameter int unsigned HOLDOFF_US    = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [20:0] echo_width,
    input  logic        no_object,
    output logic        echo,
    output logic        busy,
    output logic        trig_error,
    output logic        done
);

    localparam logic [20:0] MIN_TRIG_CNT = 21'(CLK_MHZ * MIN_TRIG_US);
    localparam logic [20:0] DELAY_LAST   = 21'(CLK_MHZ * ECHO_DELAY_US - 1);
    localparam logic [20:0] NO_OBJ_CNT   = 21'(CLK_MHZ * NO_OBJECT_US);
    localparam logic [20:0] HOLDOFF_CNT  = 21'(CLK_MHZ * HOLDOFF_US);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TRIG_HIGH = 3'd1;
    localparam logic [2:0] S_DELAY     = 3'd2;
    localparam logic [2:0] S_ECHO      = 3'd3;
    localparam logic [2:0] S_HOLDOFF   = 3'd4;

    logic        trig_meta;
    logic        trig_s;
    logic        trig_d;
    logic        trig_rise;
    logic        trig_fall;

    logic [2:0]  state;
    logic [2:0]  state_n;
    logic [20:0] cnt;
    logic [20:0] cnt_n;
    logic [20:0] w_reg;
    logic [20:0] w_n;
    logic [20:0] width_sel;
    logic        echo_n;
    logic        busy_n;
    logic        err_n;
    logic        done_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
            trig_d    <= 1'b0;
        end else begin
            trig_meta <= trigger;
            trig_s    <= trig_meta;
            trig_d    <= trig_s;
        end
    end

    assign trig_rise = trig_s & ~trig_d;
    assign trig_fall = ~trig_s & trig_d;

    // Width is resolved at the accepted fall; later input changes cannot leak in.
    always_comb begin
        if (no_object) begin
            width_sel = NO_OBJ_CNT;
        end else if (echo_width > NO_OBJ_CNT) begin
            width_sel = NO_OBJ_CNT;
        end else if (echo_width == '0) begin
            width_sel = 21'd1;
        end else begin
            width_sel = echo_width;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        w_n     = w_reg;
        echo_n  = 1'b0;
        err_n   = 1'b0;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (trig_rise) begin
                    state_n = S_TRIG_HIGH;
                    cnt_n   = 21'd1;
                end
            end
            S_TRIG_HIGH: begin
                if (trig_fall) begin
                    cnt_n = '0;
                    if (cnt >= MIN_TRIG_CNT) begin
                        state_n = S_DELAY;
                        w_n     = width_sel;
                    end else begin
                        state_n = S_IDLE;
                        err_n   = 1'b1;
                    end
                end else if (trig_s && (cnt != '1)) begin
                    cnt_n = cnt + 21'd1;
                end
            end
            S_DELAY: begin
                if (cnt == DELAY_LAST) begin
                    state_n = S_ECHO;
                    cnt_n   = '0;
                    echo_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 21'd1;
                end
            end
            S_ECHO: begin
                // echo is registered from the next-state view, so it is already
                // high on the first ECHO cycle and low on the first HOLDOFF cycle.
                if (cnt == w_reg - 21'd1) begin
                    state_n = S_HOLDOFF;
                    cnt_n   = '0;
                    done_n  = 1'b1;
                end else begin
                    cnt_n  = cnt + 21'd1;
                    echo_n = 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (cnt == HOLDOFF_CNT) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 21'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
        busy_n = (state_n == S_DELAY) || (state_n == S_ECHO) || (state_n == S_HOLDOFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            w_reg      <= 21'd1;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_error <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            w_reg      <= w_n;
            echo       <= echo_n;
            busy       <= busy_n;
            trig_error <= err_n;
            done       <= done_n;
        end
    end

endmodule
